// File: rtl/riscv_pkg.sv
// Shared types and constants for the rv32i five-stage pipeline.
//   ex_ctrl_t     : decoded control bundle carried into EX
//   EX_CTRL_NOP   : bubble control word (no writes, no branch/jump)
//   RES_*         : result-source select encodings
//   FWD_*         : EX operand-mux select encodings
//   fwd_hit()     : true when a later-stage write targets a given source index
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '{
        reg_write:  1'b0,
        result_src: RES_ALU,
        mem_write:  1'b0,
        jump:       1'b0,
        branch:     1'b0,
        alu_src:    1'b0,
        alu_ctrl:   4'd0
    };

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    function automatic logic fwd_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_fwd_sel.sv
// Forwarding select for one EX source operand.
//   rs          : source register index held in EX
//   rd_m/reg_write_m : MEM-stage destination
//   rd_w/reg_write_w : WB-stage destination
//   fwd         : FWD_MEM, FWD_WB or FWD_RF (never 2'b11)
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // MEM is younger than WB, so its value wins when both target rs.
    always_comb begin
        fwd = FWD_RF;
        if (fwd_hit(rd_m, reg_write_m, rs)) begin
            fwd = FWD_MEM;
        end else if (fwd_hit(rd_w, reg_write_w, rs)) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and EX forwarding.
//   inputs  : decode-stage indices/operands/control (*_d), MEM/WB destinations,
//             pc_src_e (taken branch/jump resolved in EX)
//   outputs : registered EX copies (*_e), forwarding selects fwd_a_e/fwd_b_e,
//             front-end controls stall_f/stall_d/flush_d, saturating
//             load-use stall counter lu_stall_cnt
// The E register is never held: a stall keeps F/D frozen and inserts a bubble.
module id_ex_hazard_reg
    import riscv_pkg::*;
#(
    parameter int W     = XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic [W-1:0]     rd1_d,
    input  logic [W-1:0]     rd2_d,
    input  logic [W-1:0]     imm_d,
    input  logic [W-1:0]     pc_d,
    input  logic [W-1:0]     pc_plus4_d,
    input  ex_ctrl_t         ctrl_d,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    input  logic             pc_src_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic [W-1:0]     rd1_e,
    output logic [W-1:0]     rd2_e,
    output logic [W-1:0]     imm_e,
    output logic [W-1:0]     pc_e,
    output logic [W-1:0]     pc_plus4_e,
    output ex_ctrl_t         ctrl_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic lu;
    logic flush_e;

    // Load-use: a load in E whose destination is read by the instruction in D.
    always_comb begin
        lu = 1'b0;
        if ((ctrl_e.result_src == RES_MEM) && (rd_e != 5'd0) &&
            ((rd_e == rs1_d) || (rd_e == rs2_d))) begin
            lu = 1'b1;
        end else begin
            lu = 1'b0;
        end
    end

    assign stall_f = lu;
    assign stall_d = lu;
    assign flush_d = pc_src_e;
    assign flush_e = lu | pc_src_e;

    // E register: bubble on stall or redirect, otherwise capture decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            rd1_e      <= {W{1'b0}};
            rd2_e      <= {W{1'b0}};
            imm_e      <= {W{1'b0}};
            pc_e       <= {W{1'b0}};
            pc_plus4_e <= {W{1'b0}};
            ctrl_e     <= EX_CTRL_NOP;
        end else if (flush_e) begin
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            rd1_e      <= {W{1'b0}};
            rd2_e      <= {W{1'b0}};
            imm_e      <= {W{1'b0}};
            pc_e       <= {W{1'b0}};
            pc_plus4_e <= {W{1'b0}};
            ctrl_e     <= EX_CTRL_NOP;
        end else begin
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_e      <= imm_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            ctrl_e     <= ctrl_d;
        end
    end

    // Load-use stall counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= {CNT_W{1'b0}};
        end else if (lu && (lu_stall_cnt != CNT_MAX)) begin
            lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
        end else begin
            lu_stall_cnt <= lu_stall_cnt;
        end
    end

    fwd_sel u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd_a_e)
    );

    fwd_sel u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd_b_e)
    );

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed self-checking bench for id_ex_hazard_reg (CNT_W = 4 so saturation
// is reachable). Expected E-register contents are pushed when decode inputs
// are driven and popped for comparison after the capturing edge.
module tb_id_ex_hazard_reg;
    import riscv_pkg::*;

    localparam int W = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] imm;
        logic [W-1:0] pc;
        logic [W-1:0] pc4;
        ex_ctrl_t     ctrl;
    } e_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1_d, rs2_d, rd_d;
    logic [W-1:0]     rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d;
    ex_ctrl_t         ctrl_d;
    logic [4:0]       rd_m, rd_w;
    logic             reg_write_m, reg_write_w, pc_src_e;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic [W-1:0]     rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    ex_ctrl_t         ctrl_e;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic             stall_f, stall_d, flush_d;
    logic [CNT_W-1:0] lu_stall_cnt;

    int   checks = 0;
    int   passed = 0;
    e_t   exp_q[$];
    e_t   model_e;
    logic [CNT_W-1:0] model_cnt;

    id_ex_hazard_reg #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .ctrl_d(ctrl_d),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .ctrl_e(ctrl_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .lu_stall_cnt(lu_stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic e_t cur_e();
        return '{rs1: rs1_e, rs2: rs2_e, rd: rd_e, rd1: rd1_e, rd2: rd2_e, imm: imm_e,
                 pc: pc_e, pc4: pc_plus4_e, ctrl: ctrl_e};
    endfunction

    function automatic e_t bubble();
        e_t b;
        b = '0;
        b.ctrl = EX_CTRL_NOP;
        return b;
    endfunction

    // Priority forwarding reference taken straight from the operand-select rules.
    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] res, input logic rw);
        rs1_d = rs1; rs2_d = rs2; rd_d = rd;
        rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
        pc_d = $urandom; pc_plus4_d = pc_d + 32'd4;
        ctrl_d = '{reg_write: rw, result_src: res, mem_write: 1'b0, jump: 1'b0,
                   branch: 1'b0, alu_src: 1'b1, alu_ctrl: 4'd2};
    endtask

    // One D->E transfer: check hazard outputs, predict E, clock, compare.
    task automatic step();
        e_t   nxt;
        e_t   got;
        logic lu_m;
        #1;
        lu_m = (model_e.ctrl.result_src == RES_MEM) && (model_e.rd != 5'd0) &&
               ((model_e.rd == rs1_d) || (model_e.rd == rs2_d));
        chk("stall_f", stall_f, lu_m);
        chk("stall_d", stall_d, lu_m);
        chk("flush_d", flush_d, pc_src_e);
        if (lu_m || pc_src_e) nxt = bubble();
        else nxt = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, rd1: rd1_d, rd2: rd2_d, imm: imm_d,
                     pc: pc_d, pc4: pc_plus4_d, ctrl: ctrl_d};
        exp_q.push_back(nxt);
        if (lu_m && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        @(posedge clk);
        #1;
        got = cur_e();
        nxt = exp_q.pop_front();
        chk("e_reg", got, nxt);
        chk("lu_cnt", lu_stall_cnt, model_cnt);
        model_e = nxt;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_e"}, cur_e(), bubble());
        chk({tag, "_nop"}, ctrl_e, EX_CTRL_NOP);
        chk({tag, "_fa"}, fwd_a_e, 2'b00);
        chk({tag, "_fb"}, fwd_b_e, 2'b00);
        chk({tag, "_cnt"}, lu_stall_cnt, 4'd0);
        chk({tag, "_st"}, {stall_f, stall_d, flush_d}, 3'b000);
    endtask

    initial begin
        // Reset with arbitrary decode/MEM/WB inputs
        rst_n = 1'b0;
        pc_src_e = 1'b0;
        set_d(5'($urandom), 5'($urandom), 5'($urandom), RES_MEM, 1'b1);
        rd_m = 5'd9; reg_write_m = 1'b1; rd_w = 5'd9; reg_write_w = 1'b1;
        #22;
        chk_reset_state("reset");
        model_e = bubble();
        model_cnt = 4'd0;
        rd_m = 5'd0; reg_write_m = 1'b0; rd_w = 5'd0; reg_write_w = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First capture: rd_e = 5 one edge later
        set_d(5'd3, 5'd4, 5'd5, RES_ALU, 1'b1);
        step();
        chk("rd_e_5", rd_e, 5'd5);

        // Forward priority on A (rs1_e = 3) and WB-only on B (rs2_e = 4)
        rd_m = 5'd3; rd_w = 5'd3; reg_write_m = 1'b1; reg_write_w = 1'b1; #1;
        chk("fwd_a_mem", fwd_a_e, 2'b10);
        chk("fwd_a_mem_ref", fwd_a_e, fwd_ref(5'd3));
        reg_write_m = 1'b0; #1;
        chk("fwd_a_wb", fwd_a_e, 2'b01);
        rd_w = 5'd4; #1;
        chk("fwd_a_rf", fwd_a_e, 2'b00);
        chk("fwd_b_wb", fwd_b_e, 2'b01);
        rd_m = 5'd4; reg_write_m = 1'b1; #1;
        chk("fwd_b_mem", fwd_b_e, 2'b10);

        // x0 is never forwarded
        set_d(5'd0, 5'd0, 5'd6, RES_ALU, 1'b1);
        step();
        rd_m = 5'd0; rd_w = 5'd0; reg_write_m = 1'b1; reg_write_w = 1'b1; #1;
        chk("fwd_a_x0", fwd_a_e, 2'b00);
        chk("fwd_b_x0", fwd_b_e, 2'b00);
        reg_write_m = 1'b0; reg_write_w = 1'b0;

        // Load-use: lw x7 into E, dependent add reads x7 on rs2
        set_d(5'd2, 5'd0, 5'd7, RES_MEM, 1'b1);
        step();
        set_d(5'd1, 5'd7, 5'd8, RES_ALU, 1'b1);
        step();                                 // stall cycle, bubble into E
        chk("lu_nop", ctrl_e, EX_CTRL_NOP);
        chk("lu_cnt1", lu_stall_cnt, 4'd1);
        step();                                 // held instruction enters E
        chk("lu_dep_rs2", rs2_e, 5'd7);
        rd_w = 5'd7; reg_write_w = 1'b1; rd_m = 5'd8; reg_write_m = 1'b0; #1;
        chk("lu_fwd_b", fwd_b_e, 2'b01);
        reg_write_w = 1'b0;

        // Taken branch: flush D and bubble E, no stall
        set_d(5'd10, 5'd11, 5'd12, RES_ALU, 1'b1);
        pc_src_e = 1'b1;
        step();
        chk("br_nop", ctrl_e, EX_CTRL_NOP);
        pc_src_e = 1'b0;

        // Simultaneous load-use and redirect
        set_d(5'd0, 5'd0, 5'd13, RES_MEM, 1'b1);
        step();
        set_d(5'd13, 5'd1, 5'd14, RES_ALU, 1'b1);
        pc_src_e = 1'b1;
        step();
        chk("both_cnt", lu_stall_cnt, 4'd2);
        pc_src_e = 1'b0;

        // Saturation: 20 more load-use events
        for (int i = 0; i < 20; i++) begin
            set_d(5'd0, 5'd0, 5'd7, RES_MEM, 1'b1);
            step();
            set_d(5'd7, 5'd3, 5'd9, RES_ALU, 1'b1);
            step();
        end
        chk("cnt_sat", lu_stall_cnt, 4'd15);

        // Async reset while a load-use stall is active
        set_d(5'd0, 5'd0, 5'd7, RES_MEM, 1'b1);
        step();
        set_d(5'd7, 5'd7, 5'd9, RES_ALU, 1'b1);
        #1;
        chk("pre_rst_stall", stall_f, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
